uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Byte buffer and launch controller directly upstream of the UART top level's transmit side. It accepts bytes from the system at full clock rate into a FIFO and hands them one at a time to the transmitter's `txStart`/`in` inputs. It handshakes on the transmitter's `txBusy` through a two-flop synchronizer, because the transmitter runs on the divided baud clock. One feeder serves one transmitter.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; never override.

Ports:
- `clk` in 1: system clock, the same clock that feeds the baud generator.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe, one byte per cycle.
- `wr_data` in 8: byte to queue.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out AW+1: current occupancy.
- `overflow` out 1: sticky; set by any write while full.
- `tx_start` out 1: drives the transmitter's `txStart`.
- `tx_data` out 8: drives the transmitter's `in`; stable for the whole transfer.
- `tx_busy` in 1: the transmitter's `txBusy`, asynchronous to `clk`.
- `sent` out 1: one-cycle pulse when a byte's transfer completes.

## Operation
- FIFO: circular buffer, AW-bit read/write pointers that wrap modulo DEPTH, plus an AW+1-bit `count`.
- Write: if `wr_en && !full`, store the byte at `wptr`, increment `wptr`, and increment `count`.
- Write while full: the byte is dropped, `overflow` is set to 1, and the FIFO is unchanged.
- `full` is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs in the same cycle.
- Write and pop in the same cycle (not full): both take effect and `count` is unchanged.
- Synchronizer: `busy_s` is `tx_busy` passed through two flops clocked by `clk`. The FSM uses only `busy_s`.
- FSM states:
  - IDLE:
    - When `!empty && !busy_s`, pop the FIFO head into the `tx_data` register.
    - Increment `rptr`, decrement `count`, and go to LAUNCH.
  - LAUNCH:
    - `tx_start` = 1.
    - Hold until `busy_s` = 1, then go to WAIT. There is no timeout.
  - WAIT:
    - `tx_start` = 0.
    - When `busy_s` = 0, pulse `sent` for one cycle and go to IDLE.
- `tx_data` changes only on the IDLE→LAUNCH transition.
- Reset, including mid-transfer:
  - State returns to IDLE, both pointers and `count` clear, and FIFO contents are discarded.
  - `tx_data` = 0, `tx_start` = 0, `sent` = 0, `overflow` = 0.
  - Both synchronizer flops clear to 0.
  - A byte already in flight in the transmitter completes on its own. The feeder launches nothing new until `busy_s` = 0.

## Timing
- Reset values: `full` = 0, `empty` = 1, `count` = 0, `overflow` = 0, `tx_start` = 0, `tx_data` = 8'h00, `sent` = 0.
- All outputs are registered.
- Write at cycle N: `count`, `empty`, and `full` update at N+1.
- Write into an empty FIFO while IDLE and `busy_s` = 0 at cycle N:
  - Pop at N+1.
  - `tx_start` = 1 and `tx_data` valid at N+2.
- `tx_start` falls 1 cycle after `busy_s` rises, which is 3 cycles after `tx_busy` rises.
- `sent` pulses 1 cycle after `busy_s` falls.
- The minimum gap between the end of one transfer and the next `tx_start` is 2 cycles (`sent` cycle, then IDLE pop).
- `tx_start` is held for at least one full baud-clock period by construction: it stays high until busy is observed.

## Configuration
- `UART_TX_FEEDER_STATS_EN`:
  - When defined, adds output `sent_total` [15:0].
  - `sent_total` increments on every `sent` pulse, wraps 16'hFFFF→0, and resets to 0.
  - When undefined, the port and counter do not exist and the behaviour is otherwise identical.

## Test plan
- Reset, then write 8'hA5 with `tx_busy` modelled as high 4 cycles after `tx_start` and lasting 100 cycles:
  - `tx_data` = 8'hA5 and `tx_start` high 2 cycles after the write.
  - `tx_start` falls 3 cycles after busy rises.
  - `sent` pulses once; `empty` = 1.
- Burst-write 16 bytes 8'h00..8'h0F with the transmitter held busy, plus a 17th write of 8'hFF:
  - `full` = 1 and `overflow` = 1.
  - Bytes then drain in order 00..0F, and 8'hFF is never sent.
- Write continuously during draining so the pointers wrap at least twice: output order equals input order across 40 bytes.
- Assert `rst` while in WAIT with 5 bytes queued:
  - All outputs return to reset values and `count` = 0.
  - After release, no `tx_start` occurs until `tx_busy` goes low and a new byte is written.
- Write on the same cycle as an IDLE pop with `count` = 3: `count` stays 3 and the written byte is sent last.
- With `UART_TX_FEEDER_STATS_EN` defined: send 3 bytes and `sent_total` = 3. Preload the counter to 16'hFFFF via force and send 1 byte: it wraps to 0.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch controller feeding a UART transmitter's txStart/in, handshaking on a synchronized txBusy.
// Optional: define UART_TX_FEEDER_STATS_EN to add the 16-bit sent_total counter output.
module uart_tx_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          sent
`ifdef UART_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]   sent_total
`endif
);

    typedef enum logic [1:0] {
        sIdle   = 2'd0,
        sLaunch = 2'd1,
        sWait   = 2'd2
    } stateT;

    stateT          state;
    stateT          stateNext;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wPtr;
    logic [AW-1:0]  rPtr;
    logic [AW:0]    countNext;
    logic           busyMeta;
    logic           busySync;
    logic           doWrite;
    logic           doPop;
    logic           txStartNext;
    logic           sentNext;

    // full is the registered pre-pop view, so a write while full is dropped even on a pop cycle
    assign doWrite = wr_en && !full;
    assign doPop   = (state == sIdle) && !empty && !busySync;

    always_comb begin
        countNext = count;
        unique case ({doWrite, doPop})
            2'b10:   countNext = count + (AW+1)'(1);
            2'b01:   countNext = count - (AW+1)'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wPtr     <= '0;
            rPtr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (doWrite)
                wPtr <= wPtr + AW'(1);
            if (doPop)
                rPtr <= rPtr + AW'(1);
            if (wr_en && full)
                overflow <= 1'b1;
            count <= countNext;
            full  <= (countNext == (AW+1)'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    // Storage carries no reset; clearing the pointers is what discards the contents
    always_ff @(posedge clk) begin
        if (doWrite)
            mem[wPtr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_data <= 8'h00;
        else if (doPop)
            tx_data <= mem[rPtr];
    end

    // txBusy comes from the baud-clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyMeta <= 1'b0;
            busySync <= 1'b0;
        end else begin
            busyMeta <= tx_busy;
            busySync <= busyMeta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= sIdle;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            sIdle:   if (!empty && !busySync) stateNext = sLaunch;
            sLaunch: if (busySync) stateNext = sWait;
            sWait:   if (!busySync) stateNext = sIdle;
            default: stateNext = sIdle;
        endcase
    end

    always_comb begin
        txStartNext = (stateNext == sLaunch);
        sentNext    = (state == sWait) && !busySync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start <= 1'b0;
            sent     <= 1'b0;
        end else begin
            tx_start <= txStartNext;
            sent     <= sentNext;
        end
    end

`ifdef UART_TX_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sent_total <= 16'h0000;
        else if (sentNext)
            sent_total <= sent_total + 16'd1;
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: behavioural transmitter model plus byte-order scoreboard.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          sent;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0]   sent_total;
`endif

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .sent(sent)
`ifdef UART_TX_FEEDER_STATS_EN
        ,
        .sent_total(sent_total)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cyc = 0;
    int sentCount = 0;
    int busyRiseCyc = 0;

    // Transmitter model: sees tx_start, raises busy busyDelay cycles later, holds it, drops it
    logic busyModel = 1'b0;
    logic busyHold  = 1'b0;
    int   busyDelay = 4;
    int   busyLen   = 100;
    bit   randomLen = 1'b0;
    logic [7:0] launched[$];

    assign tx_busy = busyModel | busyHold;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (sent === 1'b1) sentCount <= sentCount + 1;

    always begin
        @(negedge clk);
        if (tx_start === 1'b1 && rst === 1'b0) begin
            launched.push_back(tx_data);
            repeat (busyDelay) @(negedge clk);
            busyModel = 1'b1;
            busyRiseCyc = cyc;
            repeat (randomLen ? $urandom_range(2, 8) : busyLen) @(negedge clk);
            busyModel = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (full !== 1'b0) begin nFails++; $display("FAIL rst_full got %b want 0", full); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL rst_empty got %b want 1", empty); end
        nChecks++; if (count !== 5'd0) begin nFails++; $display("FAIL rst_count got %0d want 0", count); end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL rst_overflow got %b want 0", overflow); end
        nChecks++; if (tx_start !== 1'b0) begin nFails++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
        nChecks++; if (tx_data !== 8'h00) begin nFails++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        nChecks++; if (sent !== 1'b0) begin nFails++; $display("FAIL rst_sent got %b want 0", sent); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int sc0 = sentCount;
        int base = launched.size();
        busyDelay = 4; busyLen = 100; randomLen = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        nChecks++; if (count !== 5'd1) begin nFails++; $display("FAIL single_count got %0d want 1", count); end
        nChecks++; if (empty !== 1'b0) begin nFails++; $display("FAIL single_empty got %b want 0", empty); end
        @(negedge clk);
        nChecks++; if (tx_start !== 1'b1) begin nFails++; $display("FAIL single_tx_start got %b want 1", tx_start); end
        nChecks++; if (tx_data !== 8'hA5) begin nFails++; $display("FAIL single_tx_data got %h want a5", tx_data); end
        for (int i = 0; i < 50 && tx_start === 1'b1; i++) @(negedge clk);
        nChecks++; if (tx_start !== 1'b0) begin nFails++; $display("FAIL single_fall_timeout got %b want 0", tx_start); end
        nChecks++; if (cyc - busyRiseCyc !== 3) begin nFails++; $display("FAIL single_fall_delay got %0d want 3", cyc - busyRiseCyc); end
        nChecks++; if (tx_data !== 8'hA5) begin nFails++; $display("FAIL single_data_hold got %h want a5", tx_data); end
        for (int i = 0; i < 300 && sentCount == sc0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        nChecks++; if (sentCount - sc0 !== 1) begin nFails++; $display("FAIL single_sent got %0d want 1", sentCount - sc0); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL single_empty_end got %b want 1", empty); end
        nChecks++; if (launched.size() - base !== 1) begin nFails++; $display("FAIL single_launches got %0d want 1", launched.size() - base); end
    endtask

    task automatic test_overflow();
        int sc0 = sentCount;
        int base = launched.size();
        busyHold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        nChecks++; if (full !== 1'b1) begin nFails++; $display("FAIL ovf_full got %b want 1", full); end
        nChecks++; if (count !== 5'd16) begin nFails++; $display("FAIL ovf_count got %0d want 16", count); end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL ovf_early got %b want 0", overflow); end
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        nChecks++; if (count !== 5'd16) begin nFails++; $display("FAIL ovf_count_after got %0d want 16", count); end
        randomLen = 1'b1;
        busyHold = 1'b0;
        for (int i = 0; i < 3000 && sentCount < sc0 + DEPTH; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        nChecks++; if (launched.size() - base !== DEPTH) begin nFails++; $display("FAIL ovf_nbytes got %0d want %0d", launched.size() - base, DEPTH); end
        for (int i = 0; i < DEPTH && base + i < launched.size(); i++) begin
            nChecks++; if (launched[base + i] !== 8'(i)) begin nFails++; $display("FAIL ovf_order[%0d] got %h want %h", i, launched[base + i], 8'(i)); end
        end
        nChecks++; if (overflow !== 1'b1) begin nFails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL ovf_empty got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] expQ[$];
        int sc0, base, guard;
        doReset();
        sc0 = sentCount;
        base = launched.size();
        randomLen = 1'b1;
        guard = 0;
        while (expQ.size() < 40 && guard < 5000) begin
            busyDelay = $urandom_range(1, 6);
            if (full === 1'b0 && $urandom_range(0, 2) != 0) begin
                wr_en = 1'b1; wr_data = 8'($urandom);
                expQ.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        wr_en = 1'b0;
        busyDelay = 4;
        for (int i = 0; i < 4000 && sentCount < sc0 + 40; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        nChecks++; if (launched.size() - base !== 40) begin nFails++; $display("FAIL wrap_nbytes got %0d want 40", launched.size() - base); end
        for (int i = 0; i < expQ.size() && base + i < launched.size(); i++) begin
            nChecks++; if (launched[base + i] !== expQ[i]) begin nFails++; $display("FAIL wrap_order[%0d] got %h want %h", i, launched[base + i], expQ[i]); end
        end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL wrap_overflow got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        int sc0 = sentCount;
        int base = launched.size();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        randomLen = 1'b1;
        busyHold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = b[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        nChecks++; if (count !== 5'd3) begin nFails++; $display("FAIL b2b_count_pre got %0d want 3", count); end
        busyHold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_data = b[3];
        @(negedge clk);
        wr_en = 1'b0;
        nChecks++; if (tx_start !== 1'b1) begin nFails++; $display("FAIL b2b_popped got %b want 1", tx_start); end
        nChecks++; if (count !== 5'd3) begin nFails++; $display("FAIL b2b_count got %0d want 3", count); end
        for (int i = 0; i < 1000 && sentCount < sc0 + 4; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        nChecks++; if (launched.size() - base !== 4) begin nFails++; $display("FAIL b2b_nbytes got %0d want 4", launched.size() - base); end
        for (int i = 0; i < 4 && base + i < launched.size(); i++) begin
            nChecks++; if (launched[base + i] !== b[i]) begin nFails++; $display("FAIL b2b_order[%0d] got %h want %h", i, launched[base + i], b[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        int sc0, base;
        busyHold = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        randomLen = 1'b0; busyLen = 100; busyDelay = 4;
        busyHold = 1'b0;
        for (int i = 0; i < 50 && tx_start !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 50 && tx_start === 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        nChecks++; if (count !== 5'd5) begin nFails++; $display("FAIL mid_count_pre got %0d want 5", count); end
        nChecks++; if (tx_busy !== 1'b1) begin nFails++; $display("FAIL mid_busy_pre got %b want 1", tx_busy); end
        sc0 = sentCount;
        rst = 1'b1;
        @(negedge clk);
        nChecks++; if (count !== 5'd0) begin nFails++; $display("FAIL mid_count got %0d want 0", count); end
        nChecks++; if (empty !== 1'b1) begin nFails++; $display("FAIL mid_empty got %b want 1", empty); end
        nChecks++; if (full !== 1'b0) begin nFails++; $display("FAIL mid_full got %b want 0", full); end
        nChecks++; if (overflow !== 1'b0) begin nFails++; $display("FAIL mid_overflow got %b want 0", overflow); end
        nChecks++; if (tx_start !== 1'b0) begin nFails++; $display("FAIL mid_tx_start got %b want 0", tx_start); end
        nChecks++; if (tx_data !== 8'h00) begin nFails++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
        nChecks++; if (sent !== 1'b0) begin nFails++; $display("FAIL mid_sent got %b want 0", sent); end
        @(negedge clk);
        rst = 1'b0;
        base = launched.size();
        for (int i = 0; i < 300 && busyModel === 1'b1; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        nChecks++; if (launched.size() - base !== 0) begin nFails++; $display("FAIL mid_no_launch got %0d want 0", launched.size() - base); end
        nChecks++; if (sentCount - sc0 !== 0) begin nFails++; $display("FAIL mid_no_sent got %0d want 0", sentCount - sc0); end
        randomLen = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 300 && sentCount == sc0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        nChecks++; if (launched.size() - base !== 1) begin nFails++; $display("FAIL mid_relaunch got %0d want 1", launched.size() - base); end
        if (launched.size() > base) begin
            nChecks++; if (launched[base] !== 8'h3C) begin nFails++; $display("FAIL mid_relaunch_data got %h want 3c", launched[base]); end
        end
    endtask

`ifdef UART_TX_FEEDER_STATS_EN
    task automatic test_stats();
        int sc0;
        doReset();
        randomLen = 1'b1;
        sc0 = sentCount;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 1000 && sentCount < sc0 + 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        nChecks++; if (sent_total !== 16'd3) begin nFails++; $display("FAIL stats_total got %0d want 3", sent_total); end
        force dut.sent_total = 16'hFFFF;
        @(negedge clk);
        release dut.sent_total;
        sc0 = sentCount;
        wr_en = 1'b1; wr_data = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 500 && sentCount == sc0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        nChecks++; if (sent_total !== 16'd0) begin nFails++; $display("FAIL stats_wrap got %0d want 0", sent_total); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
`ifdef UART_TX_FEEDER_STATS_EN
        test_stats();
`endif
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
